// File: rtl/ex_div.sv
// Iterative restoring divider for DIV/DIVU in the EX stage: one quotient bit per cycle,
// pipeline stall while busy, single-cycle result_valid pulse on completion.
module ex_div #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             annul,
  output logic             stallreq,
  output logic             result_valid,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_zero
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH:0]   rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic             neg_quo_q, neg_quo_d;
  logic             neg_rem_q, neg_rem_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             div_zero_q, div_zero_d;

  logic [WIDTH+1:0] rem_sh;
  logic [WIDTH+1:0] diff;
  logic             q_bit;
  logic [WIDTH-1:0] quo_nx;
  logic [WIDTH:0]   rem_nx;
  logic [WIDTH-1:0] dvd_mag;
  logic [WIDTH-1:0] dvs_mag;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      dvs_q       <= '0;
      neg_quo_q   <= 1'b0;
      neg_rem_q   <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      div_zero_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      dvs_q       <= dvs_d;
      neg_quo_q   <= neg_quo_d;
      neg_rem_q   <= neg_rem_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      div_zero_q  <= div_zero_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    dvs_d       = dvs_q;
    neg_quo_d   = neg_quo_q;
    neg_rem_d   = neg_rem_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    div_zero_d  = div_zero_q;

    dvd_mag = (signed_op && dividend[WIDTH-1]) ? WIDTH'(0) - dividend : dividend;
    dvs_mag = (signed_op && divisor[WIDTH-1])  ? WIDTH'(0) - divisor  : divisor;

    // Restoring step: quo_q doubles as the dividend shift register, quotient bits enter at the LSB.
    rem_sh = {rem_q, quo_q[WIDTH-1]};
    diff   = rem_sh - {2'b00, dvs_q};
    q_bit  = ~diff[WIDTH+1];
    quo_nx = {quo_q[WIDTH-2:0], q_bit};
    rem_nx = q_bit ? diff[WIDTH:0] : rem_sh[WIDTH:0];

    if (annul) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            if (divisor == '0) begin
              quotient_d  = '1;
              remainder_d = dividend;
              div_zero_d  = 1'b1;
              state_d     = S_DONE;
            end else begin
              rem_d     = '0;
              quo_d     = dvd_mag;
              dvs_d     = dvs_mag;
              neg_quo_d = signed_op & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
              neg_rem_d = signed_op & dividend[WIDTH-1];
              cnt_d     = '0;
              state_d   = S_RUN;
            end
          end
        end
        S_RUN: begin
          rem_d = rem_nx;
          quo_d = quo_nx;
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(WIDTH - 1)) begin
            quotient_d  = neg_quo_q ? WIDTH'(0) - quo_nx : quo_nx;
            remainder_d = neg_rem_q ? WIDTH'(0) - rem_nx[WIDTH-1:0] : rem_nx[WIDTH-1:0];
            div_zero_d  = 1'b0;
            state_d     = S_DONE;
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Handshake with the pipeline is decoded from state and live inputs so annul takes effect in-cycle.
  assign stallreq     = ~annul & (((state_q == S_IDLE) & start) | (state_q == S_RUN));
  assign result_valid = ~annul & (state_q == S_DONE);
  assign quotient     = quotient_q;
  assign remainder    = remainder_q;
  assign div_zero     = div_zero_q;

endmodule

// File: tb/tb_ex_div.sv
// Self-checking bench for ex_div: directed corner cases plus randomized DIV/DIVU
// checked cycle by cycle against an arithmetic reference model.
module tb_ex_div;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic         signed_op = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         annul = 1'b0;
  logic         stallreq;
  logic         result_valid;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_zero;

  int n_vec = 0;
  int n_err = 0;

  ex_div #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .signed_op    (signed_op),
    .dividend     (dividend),
    .divisor      (divisor),
    .annul        (annul),
    .stallreq     (stallreq),
    .result_valid (result_valid),
    .quotient     (quotient),
    .remainder    (remainder),
    .div_zero     (div_zero)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reference: plain integer division, truncating toward zero, in 64-bit to absorb overflow.
  function automatic void ref_div(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] q, output logic [W-1:0] r, output logic dz);
    longint sa;
    longint sb;
    if (b == '0) begin
      q = '1; r = a; dz = 1'b1;
    end else if (!s) begin
      q = a / b; r = a % b; dz = 1'b0;
    end else begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q = W'(sa / sb); r = W'(sa % sb); dz = 1'b0;
    end
  endfunction

  // Issue one divide in the current cycle and follow it to completion; ends in the cycle after DONE.
  task automatic run_div(input logic s, input logic [W-1:0] a, input logic [W-1:0] b, input bit hold);
    logic [W-1:0] eq;
    logic [W-1:0] er;
    logic         edz;
    int           lat;
    ref_div(s, a, b, eq, er, edz);
    lat = (b == '0) ? 1 : W + 1;
    signed_op = s; dividend = a; divisor = b; start = 1'b1; annul = 1'b0;
    #1;
    n_vec++;
    if (stallreq !== 1'b1) begin
      n_err++; $display("FAIL stall_c0 op=%h/%h: got %b expected 1", a, b, stallreq);
    end
    for (int c = 1; c <= lat; c++) begin
      tick;
      if (!hold) begin
        start = 1'b0; signed_op = $urandom_range(0, 1); dividend = $urandom; divisor = $urandom;
      end
      #1;
      n_vec++;
      if (stallreq !== (c < lat)) begin
        n_err++; $display("FAIL stall_c%0d op=%h/%h: got %b expected %b", c, a, b, stallreq, c < lat);
      end
      n_vec++;
      if (result_valid !== (c == lat)) begin
        n_err++; $display("FAIL valid_c%0d op=%h/%h: got %b expected %b", c, a, b, result_valid, c == lat);
      end
      if (c == lat) begin
        n_vec++;
        if (quotient !== eq) begin
          n_err++; $display("FAIL quotient s=%b op=%h/%h: got %h expected %h", s, a, b, quotient, eq);
        end
        n_vec++;
        if (remainder !== er) begin
          n_err++; $display("FAIL remainder s=%b op=%h/%h: got %h expected %h", s, a, b, remainder, er);
        end
        n_vec++;
        if (div_zero !== edz) begin
          n_err++; $display("FAIL div_zero s=%b op=%h/%h: got %b expected %b", s, a, b, div_zero, edz);
        end
      end
    end
    tick;
    start = 1'b0;
    #1;
    n_vec++;
    if (result_valid !== 1'b0) begin
      n_err++; $display("FAIL valid_after op=%h/%h: got %b expected 0", a, b, result_valid);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b1; dividend = 32'd50; divisor = 32'd5;
    tick; tick;
    rst = 1'b0; start = 1'b0;
    #1;
    n_vec++;
    if ({stallreq, result_valid, div_zero} !== 3'b000) begin
      n_err++; $display("FAIL reset_ctrl: got %b expected 000", {stallreq, result_valid, div_zero});
    end
    n_vec++;
    if ({quotient, remainder} !== {2*W{1'b0}}) begin
      n_err++; $display("FAIL reset_data: got %h %h expected 0 0", quotient, remainder);
    end
  endtask

  task automatic test_directed;
    tick;
    run_div(1'b0, 32'd100, 32'd7, 1'b1);
    run_div(1'b1, 32'hFFFF_FFF9, 32'd2, 1'b0);
    run_div(1'b0, 32'h1234_5678, 32'd0, 1'b0);
    run_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    run_div(1'b1, 32'h8000_0000, 32'd0, 1'b1);
    run_div(1'b0, 32'hFFFF_FFFF, 32'd1, 1'b0);
    run_div(1'b1, 32'd7, 32'hFFFF_FFFE, 1'b0);
  endtask

  task automatic test_annul;
    tick;
    signed_op = 1'b0; dividend = 32'd100; divisor = 32'd7; start = 1'b1;
    for (int c = 1; c <= 9; c++) begin
      tick;
      n_vec++;
      if ({stallreq, result_valid} !== 2'b10) begin
        n_err++; $display("FAIL annul_run_c%0d: got %b expected 10", c, {stallreq, result_valid});
      end
    end
    tick; annul = 1'b1; #1;
    n_vec++;
    if ({stallreq, result_valid} !== 2'b00) begin
      n_err++; $display("FAIL annul_c10: got %b expected 00", {stallreq, result_valid});
    end
    tick; annul = 1'b0; start = 1'b0; #1;
    n_vec++;
    if ({stallreq, result_valid} !== 2'b00) begin
      n_err++; $display("FAIL annul_c11: got %b expected 00", {stallreq, result_valid});
    end
    tick;
    run_div(1'b0, 32'd9, 32'd3, 1'b0);
    // Annul landing on the DONE cycle suppresses the result.
    signed_op = 1'b0; dividend = 32'd55; divisor = 32'd5; start = 1'b1;
    tick; start = 1'b0;
    for (int c = 2; c <= W + 1; c++) tick;
    annul = 1'b1; #1;
    n_vec++;
    if ({stallreq, result_valid} !== 2'b00) begin
      n_err++; $display("FAIL annul_done: got %b expected 00", {stallreq, result_valid});
    end
    // Annul beats start in IDLE: nothing is accepted.
    tick; start = 1'b1; annul = 1'b1; #1;
    n_vec++;
    if (stallreq !== 1'b0) begin
      n_err++; $display("FAIL annul_idle_stall: got %b expected 0", stallreq);
    end
    tick; start = 1'b0; annul = 1'b0;
    for (int c = 0; c < W + 3; c++) begin
      tick;
      n_vec++;
      if ({stallreq, result_valid} !== 2'b00) begin
        n_err++; $display("FAIL annul_idle_c%0d: got %b expected 00", c, {stallreq, result_valid});
      end
    end
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 4; i++) begin
      run_div(1'($urandom_range(0, 1)), $urandom, $urandom >> $urandom_range(4, 28), 1'b1);
    end
    run_div(1'b0, 32'd17, 32'd0, 1'b1);
    run_div(1'b1, 32'hFFFF_FF00, 32'd3, 1'b1);
  endtask

  task automatic test_reset_mid_run;
    signed_op = 1'b0; dividend = 32'hDEAD_BEEF; divisor = 32'd3; start = 1'b1;
    for (int c = 0; c < 6; c++) tick;
    rst = 1'b1; tick; rst = 1'b0; start = 1'b0; #1;
    n_vec++;
    if ({stallreq, result_valid, div_zero, quotient, remainder} !== {(2*W+3){1'b0}}) begin
      n_err++; $display("FAIL reset_mid_run: got %b%b%b %h %h expected all 0",
                        stallreq, result_valid, div_zero, quotient, remainder);
    end
    for (int c = 0; c < W + 3; c++) begin
      tick;
      n_vec++;
      if ({stallreq, result_valid} !== 2'b00) begin
        n_err++; $display("FAIL reset_idle_c%0d: got %b expected 00", c, {stallreq, result_valid});
      end
    end
  endtask

  task automatic test_random;
    logic [W-1:0] a;
    logic [W-1:0] b;
    for (int i = 0; i < 60; i++) begin
      a = $urandom;
      if ($urandom_range(0, 9) == 0) a = 32'h8000_0000;
      case ($urandom_range(0, 7))
        0:       b = '0;
        1:       b = '1;
        2:       b = W'($urandom_range(1, 15));
        3:       b = 32'h8000_0000;
        default: b = $urandom >> $urandom_range(0, 31);
      endcase
      if ($urandom_range(0, 1) == 1) tick;
      run_div(1'($urandom_range(0, 1)), a, b, 1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    test_reset;
    test_directed;
    test_annul;
    test_back_to_back;
    test_reset_mid_run;
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ex_div.md
EX_DIV -- requirements
Module: ex_div

Interface
- REQ-001 Parameter: WIDTH, default 32, operand/result width; iteration count equals WIDTH.
- REQ-002 Ports, one per line:
  - clk  input  1  clock; all state changes on posedge.
  - rst  input  1  reset, synchronous, active-high.
  - start  input  1  EX holds a DIV/DIVU with valid operands; held high while EX is stalled.
  - signed_op  input  1  1 = DIV (two's complement), 0 = DIVU; sampled with start.
  - dividend  input  WIDTH  rs operand; sampled with start.
  - divisor  input  WIDTH  rt operand; sampled with start.
  - annul  input  1  flush of the EX instruction; aborts any operation.
  - stallreq  output  1  request to hold PC/IF/ID/EX and insert a bubble into MEM.
  - result_valid  output  1  quotient/remainder valid this cycle; EX forwards to HI/LO write path.
  - quotient  output  WIDTH  LO value.
  - remainder  output  WIDTH  HI value.
  - div_zero  output  1  divisor was zero; qualified by result_valid.

Function
- REQ-003 States: IDLE, RUN, DONE.
- REQ-004 IDLE with start=1 and annul=0 SHALL latch operands and signed_op, clear iteration counter, go to RUN.
- REQ-005 IDLE with start=1 and divisor=0 SHALL go directly to DONE with quotient = all ones, remainder = dividend, div_zero = 1.
- REQ-006 RUN SHALL perform one restoring radix-2 step per cycle on operand magnitudes, MSB first.
  - Partial remainder is WIDTH+1 bits.
  - Counter is log2(WIDTH)+1 bits.
  - After WIDTH steps, go to DONE.
- REQ-007 Signed op: divide magnitudes.
  - Quotient negated when sign(dividend) XOR sign(divisor) = 1.
  - Remainder negated when sign(dividend) = 1.
  - Results truncated to WIDTH.
- REQ-008 Signed most-negative / -1 SHALL yield quotient = most-negative and remainder = 0 (natural wrap), div_zero = 0.
- REQ-009 DONE SHALL assert result_valid for exactly one cycle, then go to IDLE unconditionally.
  - start is ignored in DONE; the stalled instruction advances this cycle.
- REQ-010 stallreq SHALL be combinational: (IDLE and start and not annul) or RUN.
  - stallreq SHALL be 0 in DONE.
- REQ-011 Latency: start accepted at cycle 0, result_valid at cycle WIDTH+1 (33 for WIDTH=32).
  - Divide-by-zero: result_valid at cycle 1.
  - stallreq high cycles 0..WIDTH (0 only for divide-by-zero).
- REQ-012 quotient/remainder SHALL hold their last DONE values until the next DONE.
  - They are don't-care outside result_valid but SHALL NOT be X after reset.
- REQ-013 annul in any state SHALL force IDLE next cycle.
  - result_valid and stallreq are 0 in the annul cycle.
  - No result is produced for the aborted operation.
  - annul has priority over start.
- REQ-014 A new start in the cycle after DONE (IDLE) SHALL be accepted normally.
  - Back-to-back divides run with no gap beyond DONE.

Reset
- REQ-015 rst SHALL, on posedge, set state = IDLE and counter = 0.
  - quotient, remainder, div_zero and all internal registers SHALL be 0.
  - result_valid = 0, stallreq = 0 from the cycle after reset.
- REQ-016 rst SHALL take priority over annul and start.
  - rst during RUN or DONE SHALL discard the operation with no result_valid.

Verification
- REQ-017 DIVU 100/7, start held -> stallreq cycles 0-32; cycle 33: result_valid=1, quotient=14, remainder=2, div_zero=0.
- REQ-018 DIV 0xFFFFFFF9 / 2 -> cycle 33: quotient=0xFFFFFFFD, remainder=0xFFFFFFFF.
- REQ-019 DIVU 0x12345678 / 0 -> cycle 1: result_valid=1, div_zero=1, quotient=0xFFFFFFFF, remainder=0x12345678; no RUN cycles.
- REQ-020 DIV 0x80000000 / 0xFFFFFFFF -> cycle 33: quotient=0x80000000, remainder=0.
- REQ-021 annul at cycle 10 of a run, then start at cycle 12 with 9/3:
  - cycle 11 IDLE, stallreq=0, no result_valid.
  - cycle 45: quotient=3, remainder=0.
- REQ-022 start held through DONE and asserted again in the next IDLE -> exactly one result_valid per accepted start; rst asserted mid-RUN -> all outputs 0, no result_valid.
